reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_reg_op_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
// Four-state instruction sequencer that drives an external three-port
// register file. Each instruction goes IDLE -> READ -> EXEC -> WRITE:
// the sources are read, the ALU result and flags are computed, and the
// result is then written back. The result and flags stay visible until
// the next WRITE.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   instr_valid/ready   : instruction handshake (ready only in IDLE)
//   op, rd, rs1, rs2    : opcode, destination and source register indices
//   imm                 : immediate operand for LDI
//   ra1, ra2, rd1, rd2  : register-file read addresses and combinational data
//   we3, wa3, wd3       : register-file write port
//   done                : one-cycle completion pulse, high during WRITE
//   result, zero, carry : last computed value and its status flags

module reg_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       op,
    input  logic [2:0]       rd,
    input  logic [2:0]       rs1,
    input  logic [2:0]       rs2,
    input  logic [WIDTH-1:0] imm,
    output logic [2:0]       ra1,
    output logic [2:0]       ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             we3,
    output logic [2:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_CMP = 3'b111
    } opcode_t;

    state_t           state;
    opcode_t          op_q;
    logic [2:0]       rd_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum_ext;

    // Ready is gated by rst so it is low during reset and rises in the
    // very first cycle after reset is released.
    assign instr_ready = (state == IDLE) && !rst;

    // The extra top bit of the sum is the ADD carry-out.
    assign sum_ext = {1'b0, opa} + {1'b0, opb};

    // ALU operating on the operands latched at the end of READ.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                alu_res   = opa - opb;
                alu_carry = (opa < opb);
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_MOV: alu_res = opa;
            OP_LDI: alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    // Sequencer FSM. The write-port and status outputs are loaded at the
    // end of EXEC so they are valid throughout WRITE. we3 and done default
    // low, so they pulse for exactly one cycle. Reset in any state drops
    // the in-flight op before it reaches WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            rd_q   <= '0;
            imm_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            ra1    <= '0;
            ra2    <= '0;
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            we3  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode_t'(op);
                        rd_q  <= rd;
                        imm_q <= imm;
                        ra1   <= rs1;
                        ra2   <= rs2;
                        state <= READ;
                    end
                end
                READ: begin
                    opa   <= rd1;
                    opb   <= rd2;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    carry  <= alu_carry;
                    wa3    <= rd_q;
                    wd3    <= alu_res;
                    // Register 0 is read-only zero; CMP only updates flags.
                    we3    <= (op_q != OP_CMP) && (rd_q != 3'd0);
                    done   <= 1'b1;
                    state  <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer
// Directed testbench for reg_op_sequencer. A behavioural 8-entry register
// file is attached to the read/write ports; expected values are hand
// computed per scenario.

module tb_reg_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] op = '0;
    logic [2:0] rd = '0;
    logic [2:0] rs1 = '0;
    logic [2:0] rs2 = '0;
    logic [7:0] imm = '0;
    logic [2:0] ra1, ra2;
    logic [7:0] rd1, rd2;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic       done;
    logic [7:0] result;
    logic       zero, carry;

    int checks = 0;
    int failures = 0;

    // Register file model: combinational read, write on rising edge.
    // Writes to r0 are honoured so an illegal r0 write is observable.
    logic [7:0] rf [8] = '{default: 8'h00};
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];
    always @(posedge clk) if (we3) rf[wa3] <= wd3;

    always #5 clk = ~clk;

    reg_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .done(done), .result(result), .zero(zero), .carry(carry)
    );

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, MOV = 3'd5, LDI = 3'd6, CMP = 3'd7;

    // Issues one instruction and watches cycles N+1..N+4 after acceptance.
    // we_off is the cycle offset of the last we3 seen, ready_mask has bit k
    // set if instr_ready was high in cycle N+k.
    task automatic do_op(input logic [2:0] o, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [7:0] im,
                         output int we_off, output int we_cnt,
                         output int done_cnt, output int ready_mask);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_timeout: instr_ready=%0b required 1", instr_ready);
        end
        instr_valid = 1'b1;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op = 3'($urandom); rd = 3'($urandom);
        rs1 = 3'($urandom); rs2 = 3'($urandom); imm = 8'($urandom);
        we_off = -1; we_cnt = 0; done_cnt = 0; ready_mask = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (we3) begin we_cnt++; we_off = k; end
            if (done) done_cnt++;
            if (instr_ready) ready_mask |= (1 << k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        op = LDI; rd = 3'd1; imm = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if ({instr_ready, we3, done, zero, carry} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: ready/we3/done/zero/carry=%b required 00000",
                     {instr_ready, we3, done, zero, carry});
        end
        checks++;
        if ({ra1, ra2, wa3, wd3, result} !== 25'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: ra1=%h ra2=%h wa3=%h wd3=%h result=%h required all 0",
                     ra1, ra2, wa3, wd3, result);
        end
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_ldi_add();
        int wo, wc, dc, rm;
        do_op(LDI, 3'd1, 3'd0, 3'd0, 8'h7F, wo, wc, dc, rm);
        checks++;
        if (wo !== 3 || wc !== 1 || dc !== 1 || rm !== 16) begin
            failures++;
            $display("[TB] FAIL ldi1_timing: we_off=%0d we_cnt=%0d done_cnt=%0d ready_mask=%0d required 3 1 1 16",
                     wo, wc, dc, rm);
        end
        do_op(LDI, 3'd2, 3'd0, 3'd0, 8'h81, wo, wc, dc, rm);
        checks++;
        if (wo !== 3 || wc !== 1 || dc !== 1) begin
            failures++;
            $display("[TB] FAIL ldi2_timing: we_off=%0d we_cnt=%0d done_cnt=%0d required 3 1 1", wo, wc, dc);
        end
        do_op(ADD, 3'd3, 3'd1, 3'd2, 8'h00, wo, wc, dc, rm);
        checks++;
        if (wo !== 3 || wc !== 1 || dc !== 1 || rm !== 16) begin
            failures++;
            $display("[TB] FAIL add_timing: we_off=%0d we_cnt=%0d done_cnt=%0d ready_mask=%0d required 3 1 1 16",
                     wo, wc, dc, rm);
        end
        checks++;
        if (rf[3] !== 8'h00 || result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_value: r3=%h result=%h zero=%b carry=%b required 00 00 1 1",
                     rf[3], result, zero, carry);
        end
    endtask

    task automatic test_sub_cmp();
        int wo, wc, dc, rm;
        do_op(LDI, 3'd1, 3'd0, 3'd0, 8'h05, wo, wc, dc, rm);
        do_op(LDI, 3'd2, 3'd0, 3'd0, 8'h09, wo, wc, dc, rm);
        do_op(SUB, 3'd4, 3'd1, 3'd2, 8'h00, wo, wc, dc, rm);
        checks++;
        if (rf[4] !== 8'hFC || result !== 8'hFC || carry !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sub_value: r4=%h result=%h carry=%b zero=%b required FC FC 1 0",
                     rf[4], result, carry, zero);
        end
        do_op(CMP, 3'd4, 3'd2, 3'd1, 8'h00, wo, wc, dc, rm);
        checks++;
        if (wc !== 0 || dc !== 1) begin
            failures++;
            $display("[TB] FAIL cmp_strobes: we_cnt=%0d done_cnt=%0d required 0 1", wc, dc);
        end
        checks++;
        if (result !== 8'h04 || carry !== 1'b0 || zero !== 1'b0 || rf[4] !== 8'hFC) begin
            failures++;
            $display("[TB] FAIL cmp_value: result=%h carry=%b zero=%b r4=%h required 04 0 0 FC",
                     result, carry, zero, rf[4]);
        end
    endtask

    task automatic test_ldi_r0();
        int wo, wc, dc, rm;
        do_op(LDI, 3'd0, 3'd0, 3'd0, 8'hAA, wo, wc, dc, rm);
        checks++;
        if (wc !== 0 || dc !== 1 || result !== 8'hAA || rf[0] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL ldi_r0: we_cnt=%0d done_cnt=%0d result=%h r0=%h required 0 1 AA 00",
                     wc, dc, result, rf[0]);
        end
    endtask

    task automatic test_logic();
        int wo, wc, dc, rm;
        logic [2:0] lops [4] = '{AND_, OR_, XOR_, MOV};
        logic [7:0] lexp [4] = '{8'h30, 8'hFC, 8'hCC, 8'hF0};
        do_op(LDI, 3'd1, 3'd0, 3'd0, 8'hF0, wo, wc, dc, rm);
        do_op(LDI, 3'd2, 3'd0, 3'd0, 8'h3C, wo, wc, dc, rm);
        // Preset carry to 1 so a stale carry would be visible.
        do_op(SUB, 3'd7, 3'd2, 3'd1, 8'h00, wo, wc, dc, rm);
        for (int i = 0; i < 4; i++) begin
            do_op(lops[i], 3'(i + 3), 3'd1, 3'd2, 8'h00, wo, wc, dc, rm);
            checks++;
            if (result !== lexp[i] || rf[i + 3] !== lexp[i] || carry !== 1'b0 || zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL logic_op%0d: result=%h reg=%h carry=%b zero=%b required %h %h 0 0",
                         lops[i], result, rf[i + 3], carry, zero, lexp[i], lexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] bop [3] = '{LDI, ADD, XOR_};
        logic [2:0] brd [3] = '{3'd6, 3'd7, 3'd1};
        logic [2:0] bs1 [3] = '{3'd0, 3'd6, 3'd7};
        logic [2:0] bs2 [3] = '{3'd0, 3'd6, 3'd6};
        logic [7:0] bim [3] = '{8'h11, 8'h00, 8'h00};
        int acc [$];
        int idx;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (idx < 3) begin
                instr_valid = 1'b1;
                op = bop[idx]; rd = brd[idx]; rs1 = bs1[idx]; rs2 = bs2[idx]; imm = bim[idx];
            end else begin
                instr_valid = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                acc.push_back(c);
                idx++;
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (acc.size() !== 3 || acc[0] !== 0 || acc[1] !== 4 || acc[2] !== 8) begin
            failures++;
            $display("[TB] FAIL b2b_accept: count=%0d first=%0d second=%0d third=%0d required 3 0 4 8",
                     acc.size(), (acc.size() > 0) ? acc[0] : -1,
                     (acc.size() > 1) ? acc[1] : -1, (acc.size() > 2) ? acc[2] : -1);
        end
        checks++;
        if (rf[6] !== 8'h11 || rf[7] !== 8'h22 || rf[1] !== 8'h33 || result !== 8'h33) begin
            failures++;
            $display("[TB] FAIL b2b_values: r6=%h r7=%h r1=%h result=%h required 11 22 33 33",
                     rf[6], rf[7], rf[1], result);
        end
    endtask

    task automatic test_reset_midop();
        int wc, dc, waitc;
        wc = 0; dc = 0; waitc = 0;
        @(negedge clk);
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        instr_valid = 1'b1;
        op = ADD; rd = 3'd5; rs1 = 3'd2; rs2 = 3'd4; imm = 8'h00;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        if (we3) wc++;
        if (done) dc++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (we3) wc++;
        if (done) dc++;
        checks++;
        if ({instr_ready, we3, done, zero, carry} !== 5'b0 ||
            {ra1, ra2, wa3, wd3, result} !== 25'h0) begin
            failures++;
            $display("[TB] FAIL midop_reset_outputs: ready=%b we3=%b done=%b zero=%b carry=%b ra1=%h ra2=%h wa3=%h wd3=%h result=%h required all 0",
                     instr_ready, we3, done, zero, carry, ra1, ra2, wa3, wd3, result);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midop_ready_after: got %b required 1", instr_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (we3) wc++;
            if (done) dc++;
        end
        checks++;
        if (wc !== 0 || dc !== 0 || rf[5] !== 8'hCC) begin
            failures++;
            $display("[TB] FAIL midop_abandon: we_cnt=%0d done_cnt=%0d r5=%h required 0 0 CC", wc, dc, rf[5]);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_sub_cmp();
        test_ldi_r0();
        test_logic();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
